// File: rtl/acc_readout_sequencer_pkg.sv
// Shared definitions for the accumulator readout path: sequencer state encoding
// and the default accumulator width used across the datapath.
package acc_readout_sequencer_pkg;

  localparam int ACC_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/acc_readout_sequencer_snapshot_bank.sv
// Snapshot of the accumulator bank: captures all values in one cycle so the live
// accumulators can restart while the captured copy is streamed out.
module acc_snapshot_bank
  import acc_readout_sequencer_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEFAULT,
  parameter int NUM_ACC   = 8,
  parameter int IDX_W     = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         capture,
  input  logic [NUM_ACC*ACC_WIDTH-1:0] acc_bus,
  input  logic [IDX_W-1:0]             rd_idx,
  output logic [ACC_WIDTH-1:0]         rd_data
);

  logic [ACC_WIDTH-1:0] snap_q [NUM_ACC];
  logic [ACC_WIDTH-1:0] snap_d [NUM_ACC];

  always_comb begin
    for (int i = 0; i < NUM_ACC; i++) begin
      snap_d[i] = snap_q[i];
      if (capture) begin
        snap_d[i] = acc_bus[i*ACC_WIDTH +: ACC_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ACC; i++) begin
        snap_q[i] <= snap_d[i];
      end
    end
  end

  // Indices past the bank (non power-of-two NUM_ACC) read as zero.
  always_comb begin
    rd_data = '0;
    if (int'(rd_idx) < NUM_ACC) begin
      rd_data = snap_q[rd_idx];
    end
  end

endmodule

// File: rtl/acc_readout_sequencer.sv
// Accumulator readout sequencer: on start, snapshots the bank, pulses the
// accumulator clear, then streams the captured values one beat at a time.
//
// Handshake: a beat transfers on a rising edge where out_valid & out_ready are
// both high; while out_valid is high and out_ready is low, out_data, out_idx and
// out_valid hold stable and out_valid never drops before the transfer.
module acc_readout_sequencer
  import acc_readout_sequencer_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEFAULT,
  parameter int NUM_ACC   = 8,
  parameter int IDX_W     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NUM_ACC*ACC_WIDTH-1:0] acc_bus,
  output logic                         acc_clr,
  output logic [ACC_WIDTH-1:0]         out_data,
  output logic [IDX_W-1:0]             out_idx,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done,
  output seq_state_t                   dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACC - 1);

  seq_state_t           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [ACC_WIDTH-1:0] data_q, data_d;
  logic                 clr_q, clr_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 capture;
  logic [IDX_W-1:0]     next_idx;
  logic [ACC_WIDTH-1:0] next_data;

  assign next_idx = idx_q + IDX_W'(1);

  // The bank is read one entry ahead so out_data can be loaded as a register.
  acc_snapshot_bank #(
    .ACC_WIDTH (ACC_WIDTH),
    .NUM_ACC   (NUM_ACC),
    .IDX_W     (IDX_W)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst),
    .capture (capture),
    .acc_bus (acc_bus),
    .rd_idx  (next_idx),
    .rd_data (next_data)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    clr_d   = 1'b0;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          capture = 1'b1;
          idx_d   = '0;
          data_d  = acc_bus[ACC_WIDTH-1:0];
          clr_d   = 1'b1;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (valid_q && out_ready) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d  = next_idx;
            data_d = next_data;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      clr_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      clr_q   <= clr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign acc_clr   = clr_q;
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_acc_readout_sequencer.sv
// Directed bench for acc_readout_sequencer: readout, backpressure, snapshot
// isolation, ignored start, mid-stream reset and back-to-back runs.
module tb_acc_readout_sequencer;
  import acc_readout_sequencer_pkg::*;

  localparam int W = 16;
  localparam int N = 8;
  localparam int IW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [N*W-1:0]   acc_bus = '0;
  logic             out_ready = 1'b0;
  logic             acc_clr;
  logic [W-1:0]     out_data;
  logic [IW-1:0]    out_idx;
  logic             out_valid;
  logic             busy;
  logic             done;
  seq_state_t       dbg_state;

  acc_readout_sequencer #(.ACC_WIDTH(W), .NUM_ACC(N), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .acc_bus   (acc_bus),
    .acc_clr   (acc_clr),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  int n_compared = 0;
  int n_mismatched = 0;

  // ---------------- scoreboard / recorded run ----------------
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  got_data[$];
  logic [IW-1:0] got_idx[$];
  int clr_count, clr_beat, done_count, done_gap, hold_bad, busy_bad;
  bit timed_out, first_valid;

  // Drives one readout and records what it sees; the tests judge the record.
  task automatic run_stream(input int stall_beat, input int stall_len,
                            input int restart_beat, input bit corrupt);
    int  stall_left;
    int  last_xfer;
    bit  finished;
    got_data.delete();
    got_idx.delete();
    exp_q.delete();
    clr_count = 0; clr_beat = -1; done_count = 0; done_gap = -1;
    hold_bad = 0; busy_bad = 0; timed_out = 0;
    stall_left = stall_len; last_xfer = -10; finished = 0;
    for (int i = 0; i < N; i++) begin
      acc_bus[i*W +: W] = W'(i);
      exp_q.push_back(W'(i));
    end
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    first_valid = out_valid;
    for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
      if (corrupt && cyc == 0) acc_bus = '1;
      if (acc_clr) begin clr_count++; clr_beat = got_data.size(); end
      if (done) begin done_count++; done_gap = cyc - last_xfer; end
      if (out_valid && !busy) busy_bad++;
      if (!busy && cyc > 0) finished = 1;
      if (!finished) begin
        out_ready = 1'b1;
        start = 1'b0;
        if (out_valid && int'(out_idx) == stall_beat && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
          if (out_data !== W'(stall_beat)) hold_bad++;
        end
        if (out_valid && int'(out_idx) == restart_beat) start = 1'b1;
        if (out_valid && out_ready) begin
          got_data.push_back(out_data);
          got_idx.push_back(out_idx);
          last_xfer = cyc;
        end
        @(posedge clk); #1;
      end
    end
    if (!finished) timed_out = 1;
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #2;
    n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_compared++; if (acc_clr !== 1'b0) begin n_mismatched++; $display("FAIL reset_clr: got %b want 0", acc_clr); end
    n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("FAIL reset_done: got %b want 0", done); end
    n_compared++; if (out_data !== '0) begin n_mismatched++; $display("FAIL reset_data: got %h want 0", out_data); end
    n_compared++; if (out_idx !== '0) begin n_mismatched++; $display("FAIL reset_idx: got %h want 0", out_idx); end
    n_compared++; if (dbg_state !== ST_IDLE) begin n_mismatched++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_run(input string name);
    n_compared++; if (timed_out !== 1'b0) begin n_mismatched++; $display("FAIL %s_timeout: run did not finish", name); end
    n_compared++; if (first_valid !== 1'b1) begin n_mismatched++; $display("FAIL %s_latency: valid after start %b want 1", name, first_valid); end
    n_compared++; if (got_data.size() != N) begin n_mismatched++; $display("FAIL %s_beats: got %0d want %0d", name, got_data.size(), N); end
    for (int i = 0; i < N && i < got_data.size(); i++) begin
      n_compared++;
      if (got_data[i] !== exp_q[i] || got_idx[i] !== IW'(i)) begin
        n_mismatched++;
        $display("FAIL %s_beat%0d: got data %h idx %0d want data %h idx %0d", name, i, got_data[i], got_idx[i], exp_q[i], i);
      end
    end
    n_compared++; if (clr_count != 1 || clr_beat != 0) begin n_mismatched++; $display("FAIL %s_clr: got %0d pulses at beat %0d want 1 at beat 0", name, clr_count, clr_beat); end
    n_compared++; if (done_count != 1 || done_gap != 1) begin n_mismatched++; $display("FAIL %s_done: got %0d pulses gap %0d want 1 gap 1", name, done_count, done_gap); end
    n_compared++; if (busy_bad != 0) begin n_mismatched++; $display("FAIL %s_busy: valid without busy %0d times want 0", name, busy_bad); end
    n_compared++; if (dbg_state !== ST_IDLE || out_valid !== 1'b0) begin n_mismatched++; $display("FAIL %s_end: state %0d valid %b want 0 0", name, dbg_state, out_valid); end
  endtask

  task automatic test_basic;
    run_stream(-1, 0, -1, 1'b0);
    check_run("basic");
  endtask

  task automatic test_backpressure;
    run_stream(2, 3, -1, 1'b0);
    check_run("bp");
    n_compared++; if (hold_bad != 0) begin n_mismatched++; $display("FAIL bp_hold: %0d unstable stall cycles want 0", hold_bad); end
  endtask

  task automatic test_snapshot;
    run_stream(-1, 0, -1, 1'b1);
    check_run("snap");
  endtask

  task automatic test_start_busy;
    run_stream(-1, 0, 4, 1'b0);
    check_run("startbusy");
  endtask

  task automatic test_reset_mid;
    int done_seen;
    for (int i = 0; i < N; i++) acc_bus[i*W +: W] = W'(i);
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_compared++; if (out_idx !== 3'd3 || out_valid !== 1'b1) begin n_mismatched++; $display("FAIL rstmid_pre: idx %0d valid %b want 3 1", out_idx, out_valid); end
    #2 rst = 1'b0;
    #1;
    n_compared++; if (out_valid !== 1'b0 || busy !== 1'b0 || acc_clr !== 1'b0 || done !== 1'b0) begin
      n_mismatched++; $display("FAIL rstmid_drop: valid %b busy %b clr %b done %b want 0 0 0 0", out_valid, busy, acc_clr, done);
    end
    n_compared++; if (out_data !== '0 || out_idx !== '0 || dbg_state !== ST_IDLE) begin
      n_mismatched++; $display("FAIL rstmid_regs: data %h idx %0d state %0d want 0 0 0", out_data, out_idx, dbg_state);
    end
    done_seen = 0;
    repeat (2) begin @(posedge clk); #1; if (done) done_seen++; end
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; if (done) done_seen++; end
    n_compared++; if (done_seen != 0) begin n_mismatched++; $display("FAIL rstmid_nodone: got %0d done pulses want 0", done_seen); end
    run_stream(-1, 0, -1, 1'b0);
    check_run("rstmid_after");
  endtask

  task automatic test_back_to_back;
    run_stream(-1, 0, -1, 1'b0);
    check_run("b2b_first");
    run_stream(-1, 0, -1, 1'b0);
    check_run("b2b_second");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
